// File: rtl/db_buf_rd_ctrl.sv
// Read-side controller for the deblocking pixel buffer: issues wrapped sequential reads
// under a 3-credit budget and streams the returned words out through a 3-entry FIFO.
module db_buf_rd_ctrl #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned DEPTH       = 208,
  localparam int unsigned W          = PIXEL_WIDTH * 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [7:0]   base_addr_i,
  input  logic [7:0]   len_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         rd_re_o,
  output logic [7:0]   rd_addr_o,
  input  logic [W-1:0] rd_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [7:0] LastAddr = 8'(DEPTH - 1);

  logic [1:0]   state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   remain_q, remain_d;
  logic         inflight_q;
  logic [W-1:0] mem_q [3];
  logic [1:0]   wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;

  logic issue, push, pop, drain_ok;

  // Credits cover both stored words and the word still in the buffer's read pipe.
  assign issue    = (state_q == StRun) && (remain_q != 8'd0) &&
                    (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push     = inflight_q;
  assign pop      = out_valid_o && out_ready_i;
  // Leave DRAIN in the cycle of the final transfer so done_o lands one cycle later.
  assign drain_ok = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign rd_re_o     = issue;
  assign rd_addr_o   = addr_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          remain_d = len_i;
          state_d  = (len_i != 8'd0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (issue) begin
          addr_d   = (addr_q == LastAddr) ? 8'd0 : addr_q + 8'd1;
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_ok) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 8'd0;
      remain_q   <= 8'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= rd_data_i;
        wr_ptr_q        <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end

endmodule

// File: doc/db_buf_rd_ctrl.md
# db_buf_rd_ctrl

Read-side controller for the 64-bit-wide, 208-entry deblocking pixel buffer. On a start command it streams a run of consecutive buffer words, with wrap-around, through the buffer's 1-cycle-latency read port. It then delivers those words to the deblocking filter over a valid/ready stream. Downstream backpressure is absorbed by a 3-entry output FIFO with credit-based read issue, so no read data is ever lost.

## Interface
- PIXEL_WIDTH, 8, bits per pixel; word width W = PIXEL_WIDTH*8.
- DEPTH, 208, buffer entries; the address wraps from DEPTH-1 to 0.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start_i  in  1  command pulse; sampled only in IDLE.
- base_addr_i  in  8  first word address, 0..DEPTH-1.
- len_i  in  8  number of words to read, 0..DEPTH.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse when the last word is accepted downstream.
- rd_re_o  out  1  buffer read enable.
- rd_addr_o  out  8  buffer read address.
- rd_data_i  in  W  buffer read data; valid the cycle after rd_re_o.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready.
- out_data_o  out  W  stream data; equals the FIFO head.

## Operation
- FSM states:
  - IDLE: start_i=1 and len_i>0 → RUN. Load addr=base_addr_i and remain=len_i.
  - IDLE, start_i=1 and len_i=0 → DONE. No reads are issued.
  - RUN: issues reads. remain reaching 0 → DRAIN.
  - DRAIN: waits until inflight=0 and the FIFO is empty → DONE.
  - DONE: asserts done_o for one cycle → IDLE.
- A start_i that arrives outside IDLE is ignored; it is neither queued nor acknowledged.
- Read issue:
  - rd_re_o=1 when state=RUN, remain>0, and (fifo_count + inflight) < 3.
  - fifo_count is the registered occupancy before this cycle's pop.
  - On issue: rd_addr_o=addr. Then addr = (addr==DEPTH-1) ? 0 : addr+1, and remain decrements.
- inflight register: set on the cycle of issue, cleared the following cycle. Its value is 0 or 1.
- FIFO:
  - Pushes rd_data_i when inflight=1. Pops when out_valid_o and out_ready_i are both high.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule keeps the FIFO from overflowing; an overflow is an assertion failure in the bench.
- Word order on the stream is strictly the address order issued.
- out_valid_o = (fifo_count != 0).
- out_data_o holds its value while out_valid_o=1 and out_ready_i=0.

## Timing
- Reset values:
  - busy_o, done_o, rd_re_o, out_valid_o = 0.
  - rd_addr_o = 0, out_data_o = 0.
  - FSM = IDLE; FIFO and counters cleared.
- Start accepted at cycle T (IDLE):
  - busy_o=1 and rd_re_o=1 (first address) at T+1.
  - Data is pushed at T+2; out_valid_o=1 at T+3.
- With out_ready_i held at 1, one word is issued per cycle after the first. N words take N+3 cycles from T to the last transfer.
- done_o is asserted in the cycle after the last transfer. busy_o falls in the same cycle. A new start is accepted no earlier than the cycle after done_o.
- With len_i=0: done_o at T+1, busy_o stays 0, and no rd_re_o is issued.
- Under backpressure, rd_re_o deasserts once fifo_count + inflight reaches 3. Issue resumes the cycle after a pop frees a credit.
- Reset asserted mid-operation: all state is cleared asynchronously. done_o is not pulsed, and in-flight data is discarded.

## Test plan
- base=0x10, len=4, ready=1 → rd_addr 0x10..0x13 on consecutive cycles. Four consecutive transfers of those words. done_o one cycle after the 4th transfer; total 7 cycles from the start sample.
- base=206, len=4 → addresses 206, 207, 0, 1. Data arrives in that order.
- base=0, len=8, ready held 0 for 10 cycles → exactly 3 reads issued, FIFO holds 3 entries, out_data_o stable. After ready rises: 8 words delivered in order with no loss or duplication.
- len=0 start → done_o pulse at T+1, no rd_re_o, busy_o never 1. A start_i pulsed while busy → ignored; word count unchanged.
- base=0, len=208, random ready (50%) → all 208 words delivered in order. FIFO never exceeds 3 entries.
- rst_n low at the 3rd transfer of len=8 → all outputs 0 immediately. A following start (base=5, len=2) behaves as from a clean reset.
